// File: rtl/psg_pkg.sv
// Shared PSG definitions: noise rate encodings, control-field layout and LFSR helpers.
package psg_pkg;

    localparam int unsigned NOISE_CTRL_W  = 3;
    localparam int unsigned NOISE_FB_BIT  = 2;
    localparam int unsigned NOISE_NF_W    = 2;
    localparam int unsigned NOISE_CNT_W   = 6;
    localparam int unsigned LFSR_MAX_BITS = 32;

    typedef enum logic [NOISE_NF_W-1:0] {
        NOISE_RATE_16  = 2'd0,
        NOISE_RATE_32  = 2'd1,
        NOISE_RATE_64  = 2'd2,
        NOISE_RATE_EXT = 2'd3
    } noise_rate_e;

    // Seed has only the top bit of a `bits`-wide register set.
    function automatic logic [LFSR_MAX_BITS-1:0] lfsr_seed(input int unsigned bits);
        return LFSR_MAX_BITS'(1) << (bits - 1);
    endfunction

    // Terminal count (N-1) of the divider for an internal rate.
    function automatic logic [NOISE_CNT_W-1:0] rate_last(input noise_rate_e rate);
        logic [NOISE_CNT_W-1:0] last;
        case (rate)
            NOISE_RATE_16: last = NOISE_CNT_W'(15);
            NOISE_RATE_32: last = NOISE_CNT_W'(31);
            default:       last = NOISE_CNT_W'(63);
        endcase
        return last;
    endfunction

endpackage

// File: rtl/noise_lfsr.sv
// Noise shift register with white/periodic feedback select and seed reload.
module noise_lfsr
    import psg_pkg::*;
#(
    parameter int unsigned LFSR_BITS = 15,
    parameter int unsigned WHITE_TAP = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic shift,
    input  logic load,
    input  logic white,
    output logic out
);

    localparam logic [LFSR_BITS-1:0] SEED = LFSR_BITS'(lfsr_seed(LFSR_BITS));

    logic [LFSR_BITS-1:0] r_lfsr;
    logic                 w_fb;

    // Periodic mode recirculates bit 0; white mode adds the second tap.
    assign w_fb = r_lfsr[0] ^ (white & r_lfsr[WHITE_TAP]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= SEED;
        end else if (load) begin
            r_lfsr <= SEED;
        end else if (shift) begin
            r_lfsr <= {w_fb, r_lfsr[LFSR_BITS-1:1]};
        end
    end

    assign out = r_lfsr[0];

endmodule

// File: rtl/noise_generator.sv
// PSG noise channel: rate divider / tone-2 edge detector driving the noise LFSR.
module noise_generator
    import psg_pkg::*;
#(
    parameter int unsigned LFSR_BITS = 15,
    parameter int unsigned WHITE_TAP = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NOISE_CTRL_W-1:0] control,
    input  logic                    restart_noise,
    input  logic                    tone2_in,
    output logic                    out
);

    logic [NOISE_CNT_W-1:0] r_cnt;
    logic                   r_phase;
    logic                   r_tone2_q;

    noise_rate_e w_rate;
    logic        w_white;
    logic        w_ext;
    logic        w_wrap;
    logic        w_shift;

    assign w_rate  = noise_rate_e'(control[NOISE_NF_W-1:0]);
    assign w_white = control[NOISE_FB_BIT];
    assign w_ext   = (w_rate == NOISE_RATE_EXT);

    // Only the rising half of the divided clock shifts the register.
    assign w_wrap  = enable && !w_ext && (r_cnt == rate_last(w_rate));
    assign w_shift = (w_wrap && !r_phase) || (w_ext && tone2_in && !r_tone2_q);

    // Divider holds while the external rate is selected; restart clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (restart_noise) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (enable && !w_ext) begin
            if (w_wrap) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt   <= r_cnt + NOISE_CNT_W'(1);
            end
        end
    end

    // Edge detector runs every clock, independent of enable and restart.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tone2_q <= 1'b0;
        end else begin
            r_tone2_q <= tone2_in;
        end
    end

    noise_lfsr #(
        .LFSR_BITS (LFSR_BITS),
        .WHITE_TAP (WHITE_TAP)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .shift (w_shift),
        .load  (restart_noise),
        .white (w_white),
        .out   (out)
    );

endmodule
